// File: rtl/sdram_responder.sv
// sdram_responder
//   Chip-side model of a single-data-rate SDRAM, 8-bit data bus, single-beat
//   bursts only. Decodes the command strobes, tracks open rows per bank and
//   the mode register, serves reads/writes from a small internal byte array
//   and raises sticky protocol error flags.
//
// Ports
//   clk, rst_n      : clock (rising edge) and synchronous active-low reset
//   cke             : clock enable; 0 freezes command decode (read pipe runs on)
//   cs_n, ras_n,
//   cas_n, we_n     : command strobes
//   bank_addr       : bank select
//   addr[12:0]      : row / column / mode; A10 = auto-precharge / precharge-all
//   dqm             : write mask (1 = byte not written)
//   dq_in           : write data from the pad
//   dq_out, dq_oe   : read data and pad output enable (tri-state lives above)
//   mode_valid      : an MRS has been seen since reset
//   refresh_count   : REF commands accepted, wraps
//   err[5:0]        : sticky flags
//                     0 access to closed bank, 1 ACT to open bank,
//                     2 REF with a bank open, 3 tRCD violation,
//                     4 ACT/READ/WRIT before MRS, 5 unsupported mode
//
// Bus timing contract: a command is taken at edge E0 when cke=1 and cs_n=0.
// A READ's byte is on dq_out with dq_oe=1 for exactly the one cycle between
// edges E(CL-1) and E(CL); the controller samples it at E(CL).
module sdram_responder #(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 10,
    parameter int BANK_WIDTH     = 2,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int TRCD           = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cke,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [BANK_WIDTH-1:0] bank_addr,
    input  logic [12:0]           addr,
    input  logic                  dqm,
    input  logic [7:0]            dq_in,
    output logic [7:0]            dq_out,
    output logic                  dq_oe,
    output logic                  mode_valid,
    output logic [15:0]           refresh_count,
    output logic [5:0]            err
);

    localparam int NUM_BANKS = 1 << BANK_WIDTH;
    localparam int ACC_W     = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_REF  = 3'b001;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_ACT  = 3'b011;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_READ = 3'b101;

    // Bank state
    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_WIDTH-1:0] bank_row [NUM_BANKS];
    logic [2:0]           trcd_cnt [NUM_BANKS];

    // Mode state; cl3 = 1 selects CAS latency 3, else 2
    logic [12:0] mode_reg;
    logic        cl3;

    // Byte array, never reset
    logic [7:0] mem [1 << MEM_ADDR_WIDTH];

    // Read latency pipe: p0 holds a read taken at E0, p1 carries CL=3 reads one more cycle
    logic       p0_valid, p0_cl3;
    logic [7:0] p0_data;
    logic       p1_valid;
    logic [7:0] p1_data;

    logic                      cmd_en;
    logic [2:0]                cmd;
    logic [ACC_W-1:0]          acc_full;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic                      mrs_ok;
    logic                      trcd_short;
    logic                      unused_bits;

    assign cmd_en   = cke & ~cs_n;
    assign cmd      = {ras_n, cas_n, we_n};
    // Closed banks still use their last row, so a stale access hits a defined byte
    assign acc_full = {bank_addr, bank_row[bank_addr], addr[COL_WIDTH-1:0]};
    assign mem_idx  = acc_full[MEM_ADDR_WIDTH-1:0];
    // Only CL 2/3 with burst length 1 is supported
    assign mrs_ok   = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'd0);
    // Counter reads k-1 at the edge k cycles after ACT
    assign trcd_short = (int'(trcd_cnt[bank_addr]) + 1) < TRCD;
    assign unused_bits = ^{acc_full[ACC_W-1:MEM_ADDR_WIDTH], mode_reg};

    // Array and data side of the pipe
    always_ff @(posedge clk) begin
        p0_data <= mem[mem_idx];
        p1_data <= p0_data;
        if (cmd_en && (cmd == CMD_WRIT) && !dqm)
            mem[mem_idx] <= dq_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_open     <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_row[i] <= '0;
                trcd_cnt[i] <= 3'd7;
            end
            mode_reg      <= '0;
            cl3           <= 1'b1;
            mode_valid    <= 1'b0;
            refresh_count <= '0;
            err           <= '0;
            p0_valid      <= 1'b0;
            p0_cl3        <= 1'b1;
            p1_valid      <= 1'b0;
            dq_oe         <= 1'b0;
            dq_out        <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++)
                if (trcd_cnt[i] != 3'd7)
                    trcd_cnt[i] <= trcd_cnt[i] + 3'd1;

            // Pipe shifts regardless of cke
            p0_valid <= cmd_en && (cmd == CMD_READ);
            p0_cl3   <= cl3;
            p1_valid <= p0_valid && p0_cl3;
            if (p1_valid) begin
                dq_oe  <= 1'b1;
                dq_out <= p1_data;
            end else if (p0_valid && !p0_cl3) begin
                dq_oe  <= 1'b1;
                dq_out <= p0_data;
            end else begin
                dq_oe  <= 1'b0;
                dq_out <= '0;
            end

            if (cmd_en) begin
                case (cmd)
                    CMD_ACT: begin
                        if (bank_open[bank_addr]) err[1] <= 1'b1;
                        if (!mode_valid)          err[4] <= 1'b1;
                        bank_open[bank_addr] <= 1'b1;
                        bank_row[bank_addr]  <= addr[ROW_WIDTH-1:0];
                        trcd_cnt[bank_addr]  <= 3'd0;
                    end
                    CMD_READ, CMD_WRIT: begin
                        if (!bank_open[bank_addr]) err[0] <= 1'b1;
                        else if (trcd_short)       err[3] <= 1'b1;
                        if (!mode_valid)           err[4] <= 1'b1;
                        if (addr[10]) bank_open[bank_addr] <= 1'b0;
                    end
                    CMD_PRE: begin
                        if (addr[10]) bank_open <= '0;
                        else          bank_open[bank_addr] <= 1'b0;
                    end
                    CMD_REF: begin
                        refresh_count <= refresh_count + 16'd1;
                        if (|bank_open) err[2] <= 1'b1;
                    end
                    CMD_MRS: begin
                        mode_reg   <= addr;
                        mode_valid <= 1'b1;
                        cl3        <= !(mrs_ok && (addr[6:4] == 3'd2));
                        if (!mrs_ok) err[5] <= 1'b1;
                    end
                    default: ;  // BST and NOP
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed walk through the main behaviours, then
// randomized commands, all checked every cycle against a command-level model
// (open-bank table, ACT timestamps, byte array, and a queue of expected read
// beats keyed by the edge after which they appear).
module tb_sdram_responder;

    localparam int ROW_W = 13;
    localparam int COL_W = 10;
    localparam int TRCD  = 2;

    logic        clk;
    logic        rst_n, cke, cs_n, ras_n, cas_n, we_n, dqm;
    logic [1:0]  bank_addr;
    logic [12:0] addr;
    logic [7:0]  dq_in;
    logic [7:0]  dq_out;
    logic        dq_oe, mode_valid;
    logic [15:0] refresh_count;
    logic [5:0]  err;

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .bank_addr(bank_addr), .addr(addr),
        .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .mode_valid(mode_valid), .refresh_count(refresh_count), .err(err)
    );

    // Clock / edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // Reference model
    logic [7:0]  m_mem [0:4095];
    bit          m_known [0:4095];
    bit          m_open [4];
    int          m_row [4];
    int          m_act_e [4];
    bit          m_mode_valid;
    int          m_cl;
    logic [5:0]  m_err;
    logic [15:0] m_ref;

    // Scoreboard: expected read beats in order
    logic [7:0] exp_q[$];
    int         exp_t_q[$];
    bit         exp_k_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i]  = 0;
            m_row[i]   = 0;
            m_act_e[i] = -1000;
        end
        m_mode_valid = 0;
        m_cl  = 3;
        m_err = '0;
        m_ref = '0;
        exp_q.delete();
        exp_t_q.delete();
        exp_k_q.delete();
    endtask

    // Apply the currently driven inputs as seen by edge e
    task automatic model_apply(input int e);
        int b, idx, f, a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!(cke && !cs_n)) return;
        b = int'(bank_addr);
        a = int'(addr);
        case ({ras_n, cas_n, we_n})
            3'b011: begin
                if (m_open[b]) m_err[1] = 1'b1;
                if (!m_mode_valid) m_err[4] = 1'b1;
                m_open[b]  = 1;
                m_row[b]   = a;
                m_act_e[b] = e;
            end
            3'b101, 3'b100: begin
                if (!m_open[b]) m_err[0] = 1'b1;
                else if (e - m_act_e[b] < TRCD) m_err[3] = 1'b1;
                if (!m_mode_valid) m_err[4] = 1'b1;
                idx = ((b << (ROW_W + COL_W)) + (m_row[b] << COL_W) + (a % 1024)) % 4096;
                if (!we_n) begin
                    if (!dqm) begin
                        m_mem[idx]   = dq_in;
                        m_known[idx] = 1;
                    end
                end else begin
                    exp_t_q.push_back(e + m_cl - 1);
                    exp_q.push_back(m_mem[idx]);
                    exp_k_q.push_back(m_known[idx]);
                end
                if ((a / 1024) % 2 == 1) m_open[b] = 0;
            end
            3'b010: begin
                if ((a / 1024) % 2 == 1) for (int i = 0; i < 4; i++) m_open[i] = 0;
                else m_open[b] = 0;
            end
            3'b001: begin
                m_ref = m_ref + 16'd1;
                if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) m_err[2] = 1'b1;
            end
            3'b000: begin
                m_mode_valid = 1;
                f = (a / 16) % 8;
                if ((f == 2 || f == 3) && (a % 8 == 0)) m_cl = f;
                else begin
                    m_err[5] = 1'b1;
                    m_cl = 3;
                end
            end
            default: ;
        endcase
    endtask

    // Compare DUT outputs against the model for the cycle after the last edge
    task automatic check_outputs();
        bit         want_oe = 0;
        bit         known = 0;
        logic [7:0] want_d = '0;
        if (exp_t_q.size() > 0 && exp_t_q[0] == edge_n) begin
            want_oe = 1;
            want_d  = exp_q.pop_front();
            known   = exp_k_q.pop_front();
            void'(exp_t_q.pop_front());
        end
        check("dq_oe", dq_oe, want_oe);
        if (want_oe && known) check("dq_out", dq_out, want_d);
        check("err", err, m_err);
        check("mode_valid", mode_valid, m_mode_valid);
        check("refresh_count", refresh_count, m_ref);
    endtask

    // Driver: one cycle per call
    task automatic step(input bit r, input bit c, input bit cs, input logic [2:0] rcw,
                        input int b, input int a, input bit m, input int d);
        @(negedge clk);
        check_outputs();
        rst_n     = r;
        cke       = c;
        cs_n      = cs;
        {ras_n, cas_n, we_n} = rcw;
        bank_addr = b[1:0];
        addr      = a[12:0];
        dqm       = m;
        dq_in     = d[7:0];
        model_apply(edge_n + 1);
    endtask

    task automatic nop();                       step(1, 1, 0, 3'b111, 0, 0, 0, 0); endtask
    task automatic rst_cyc();                   step(0, 1, 1, 3'b111, 0, 0, 0, 0); endtask
    task automatic act(input int b, input int r); step(1, 1, 0, 3'b011, b, r, 0, 0); endtask
    task automatic rd(input int b, input int c, input bit ap);
        step(1, 1, 0, 3'b101, b, (int'(ap) << 10) | c, 0, 0);
    endtask
    task automatic wr(input int b, input int c, input bit ap, input int d, input bit m);
        step(1, 1, 0, 3'b100, b, (int'(ap) << 10) | c, m, d);
    endtask
    task automatic pre(input int b, input bit all); step(1, 1, 0, 3'b010, b, int'(all) << 10, 0, 0); endtask
    task automatic do_ref();                    step(1, 1, 0, 3'b001, 0, 0, 0, 0); endtask
    task automatic mrs(input int a);            step(1, 1, 0, 3'b000, 0, a, 0, 0); endtask

    initial begin
        rst_n = 0; cke = 1; cs_n = 1; ras_n = 1; cas_n = 1; we_n = 1;
        bank_addr = '0; addr = '0; dqm = 0; dq_in = '0;
        for (int i = 0; i < 4096; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 0;
        end
        model_reset();

        repeat (3) rst_cyc();

        // Initialisation
        pre(0, 1);
        do_ref();
        do_ref();
        mrs(12'h020);
        nop();
        check("init_mode_valid", mode_valid, 1);
        check("init_refresh", refresh_count, 2);
        check("init_err", err, 0);

        // Write then CL=2 read
        act(1, 5); nop();
        wr(1, 3, 1, 8'hA5, 0);
        act(1, 5); nop();
        rd(1, 3, 1);
        nop();
        check("cl2_no_early_oe", dq_oe, 0);
        nop();
        check("cl2_oe", dq_oe, 1);
        check("cl2_data", dq_out, 8'hA5);
        nop();
        check("cl2_oe_one_cycle", dq_oe, 0);

        // CL=3 read, then masked write
        mrs(12'h030); nop();
        act(1, 5); nop();
        rd(1, 3, 1);
        nop(); nop();
        check("cl3_no_early_oe", dq_oe, 0);
        nop();
        check("cl3_data", dq_out, 8'hA5);
        act(1, 5); nop();
        wr(1, 3, 0, 8'h00, 1);
        rd(1, 3, 1);
        nop(); nop(); nop();
        check("dqm_keeps_byte", dq_out, 8'hA5);

        // Three back-to-back reads
        act(0, 0); nop();
        wr(0, 0, 0, 8'h11, 0);
        wr(0, 1, 0, 8'h22, 0);
        wr(0, 2, 0, 8'h33, 0);
        rd(0, 0, 0);
        rd(0, 1, 0);
        rd(0, 2, 0);
        repeat (5) nop();
        pre(0, 1);
        nop();
        check("clean_err", err, 0);

        // Error flags
        act(2, 1);
        rd(2, 0, 0);
        nop();
        check("err_trcd", err, 6'b001000);
        pre(0, 1);
        rd(3, 0, 0);
        act(0, 0); nop(); nop();
        do_ref();
        mrs(12'h051);
        nop();
        check("err_all", err, 6'b101101);
        repeat (4) nop();
        check("err_sticky", err, 6'b101101);

        // Reset while a read is in flight
        rd(0, 0, 0);
        rst_cyc();
        rst_cyc();
        nop();
        check("rst_oe", dq_oe, 0);
        check("rst_err", err, 0);
        check("rst_mode_valid", mode_valid, 0);
        pre(0, 1);
        mrs(12'h020);
        act(1, 5); nop();
        rd(1, 3, 1);
        nop(); nop();
        check("array_survives_reset", dq_out, 8'hA5);

        // Randomized commands
        for (int n = 0; n < 500; n++) begin
            int sel, b, r, c, d;
            sel = $urandom_range(0, 99);
            b   = $urandom_range(0, 3);
            r   = $urandom_range(0, 3) | ($urandom_range(0, 7) << 10);
            c   = $urandom_range(0, 15);
            d   = $urandom_range(0, 255);
            if (sel < 15)      act(b, r);
            else if (sel < 40) rd(b, c, $urandom_range(0, 3) == 0);
            else if (sel < 60) wr(b, c, $urandom_range(0, 3) == 0, d, $urandom_range(0, 4) == 0);
            else if (sel < 70) pre(b, $urandom_range(0, 1) == 1);
            else if (sel < 73) do_ref();
            else if (sel < 76) mrs($urandom_range(0, 9) == 0 ? $urandom_range(0, 8191)
                                   : ($urandom_range(0, 1) == 1 ? 12'h030 : 12'h020));
            else if (sel < 84) nop();
            else if (sel < 90) step(1, 0, 0, 3'($urandom_range(0, 7)), b, r, 0, d);
            else if (sel < 95) step(1, 1, 1, 3'($urandom_range(0, 7)), b, r, 0, d);
            else               step(1, 1, 0, 3'b110, b, r, 0, d);
        end

        repeat (6) nop();
        check("no_pending_reads", exp_t_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
